// File: rtl/pic_pkg.sv
// Shared definitions for the PIC-style execute slice.
//   DATA_W / PC_W : datapath and program counter widths
//   OP_*          : 6-bit opcode field values (inst_reg[7:2])
//   alu_op_e      : 4-bit decoded ALU operation carried from decode to alu
package pic_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PC_W   = 17;

  localparam logic [5:0] OP_ADD  = 6'b000111;
  localparam logic [5:0] OP_AND  = 6'b000101;
  localparam logic [5:0] OP_IOR  = 6'b000100;
  localparam logic [5:0] OP_XOR  = 6'b000110;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_CLR  = 6'b000001;
  localparam logic [5:0] OP_MOV  = 6'b001000;
  localparam logic [5:0] OP_COM  = 6'b001001;
  localparam logic [5:0] OP_INC  = 6'b001010;
  localparam logic [5:0] OP_DEC  = 6'b000011;
  localparam logic [5:0] OP_SWAP = 6'b001110;
  localparam logic [5:0] OP_RL   = 6'b001101;
  localparam logic [5:0] OP_RR   = 6'b001100;
  localparam logic [5:0] OP_MISC = 6'b000000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_AND  = 4'b0001,
    ALU_IOR  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SUB  = 4'b0100,
    ALU_CLR  = 4'b0101,
    ALU_MOV  = 4'b0110,
    ALU_COM  = 4'b0111,
    ALU_INC  = 4'b1000,
    ALU_DEC  = 4'b1001,
    ALU_SWAP = 4'b1010,
    ALU_RL   = 4'b1011,
    ALU_RR   = 4'b1100,
    ALU_MOVW = 4'b1101,
    ALU_NOP  = 4'b1111
  } alu_op_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU. a is the W register, b is the file register operand.
//   reset : forces ans to zero while high
//   inst  : ALU operation (alu_op_e encoding)
//   a, b  : DATA_W-bit operands
//   ans   : DATA_W+1-bit result, top bit is carry/borrow/rotated-out bit
module alu
  import pic_pkg::*;
#(
  parameter int unsigned DATA_W = pic_pkg::DATA_W
) (
  input  logic              reset,
  input  logic [3:0]        inst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W:0]   ans
);

  localparam int unsigned HALF = DATA_W / 2;

  logic [DATA_W:0] a_ext;
  logic [DATA_W:0] b_ext;
  logic [DATA_W:0] one;

  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};
  assign one   = {{DATA_W{1'b0}}, 1'b1};

  always_comb begin
    ans = '0;
    if (!reset) begin
      case (alu_op_e'(inst))
        ALU_ADD:  ans = a_ext + b_ext;
        ALU_AND:  ans = {1'b0, a & b};
        ALU_IOR:  ans = {1'b0, a | b};
        ALU_XOR:  ans = {1'b0, a ^ b};
        // Modulo subtraction leaves the borrow in the top bit when b < a.
        ALU_SUB:  ans = b_ext - a_ext;
        ALU_CLR:  ans = '0;
        ALU_MOV:  ans = b_ext;
        ALU_COM:  ans = {1'b0, ~b};
        ALU_INC:  ans = b_ext + one;
        ALU_DEC:  ans = b_ext - one;
        ALU_SWAP: ans = {1'b0, b[HALF-1:0], b[DATA_W-1:HALF]};
        ALU_RL:   ans = {b[DATA_W-1], b[DATA_W-2:0], b[DATA_W-1]};
        ALU_RR:   ans = {b[0], b[0], b[DATA_W-1:1]};
        ALU_MOVW: ans = a_ext;
        default:  ans = '0;
      endcase
    end
  end

endmodule

// File: rtl/decode.sv
// Combinational instruction decoder.
//   inst_reg : instruction byte, [7:2] opcode, [1] destination, [0] ignored
//   inst     : decoded ALU operation (alu_op_e encoding)
//   d        : destination select, 0 = W, 1 = file register
module decode
  import pic_pkg::*;
(
  input  logic [7:0] inst_reg,
  output logic [3:0] inst,
  output logic       d
);

  logic [5:0] opcode;
  alu_op_e    op;
  logic       unused_bit0;

  assign opcode      = inst_reg[7:2];
  assign d           = inst_reg[1];
  assign unused_bit0 = inst_reg[0];

  always_comb begin
    op = ALU_NOP;
    case (opcode)
      OP_ADD:  op = ALU_ADD;
      OP_AND:  op = ALU_AND;
      OP_IOR:  op = ALU_IOR;
      OP_XOR:  op = ALU_XOR;
      OP_SUB:  op = ALU_SUB;
      OP_CLR:  op = ALU_CLR;
      OP_MOV:  op = ALU_MOV;
      OP_COM:  op = ALU_COM;
      OP_INC:  op = ALU_INC;
      OP_DEC:  op = ALU_DEC;
      OP_SWAP: op = ALU_SWAP;
      OP_RL:   op = ALU_RL;
      OP_RR:   op = ALU_RR;
      // All-zero opcode is MOVW only when writing to f; with d=0 it is a NOP.
      OP_MISC: op = inst_reg[1] ? ALU_MOVW : ALU_NOP;
      default: op = ALU_NOP;
    endcase
  end

  assign inst = op;

endmodule

// File: rtl/pcounter.sv
// Free-running program counter.
//   clk     : rising-edge clock
//   reset   : asynchronous active-high clear
//   counter : current count, increments every clock, wraps to 0
module pcounter
  import pic_pkg::*;
#(
  parameter int unsigned PC_W = pic_pkg::PC_W
) (
  input  logic            clk,
  input  logic            reset,
  output logic [PC_W-1:0] counter
);

  logic [PC_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + {{(PC_W-1){1'b0}}, 1'b1};
    end
  end

  assign counter = count_q;

endmodule

// File: rtl/pic_exec_slice.sv
// Execute-stage slice: program counter, instruction decoder and ALU.
//   clk      : system clock
//   reset    : asynchronous active-high reset (counter and ans)
//   inst_reg : instruction byte
//   b        : file-register operand
//   w        : W-register operand
//   counter  : program counter
//   inst     : decoded ALU op
//   d        : destination, 0 = W, 1 = file register
//   ans      : ALU result with carry/borrow in the top bit
module pic_exec_slice
  import pic_pkg::*;
#(
  parameter int unsigned PC_W   = pic_pkg::PC_W,
  parameter int unsigned DATA_W = pic_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        inst_reg,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] w,
  output logic [PC_W-1:0]   counter,
  output logic [3:0]        inst,
  output logic              d,
  output logic [DATA_W:0]   ans
);

  logic [3:0] dec_inst;

  pcounter #(.PC_W(PC_W)) u_pc (
    .clk     (clk),
    .reset   (reset),
    .counter (counter)
  );

  decode u_dec (
    .inst_reg (inst_reg),
    .inst     (dec_inst),
    .d        (d)
  );

  alu #(.DATA_W(DATA_W)) u_alu (
    .reset (reset),
    .inst  (dec_inst),
    .a     (w),
    .b     (b),
    .ans   (ans)
  );

  assign inst = dec_inst;

endmodule

// File: tb/tb_pic_exec_slice.sv
module tb_pic_exec_slice;

  logic        clk;
  logic        reset;
  logic [7:0]  inst_reg;
  logic [7:0]  b;
  logic [7:0]  w;
  logic [16:0] counter;
  logic [3:0]  inst;
  logic        d;
  logic [8:0]  ans;

  logic [3:0]  s_counter;
  logic [3:0]  s_inst;
  logic        s_d;
  logic [8:0]  s_ans;

  int n_checks;
  int n_fail;

  pic_exec_slice dut (
    .clk      (clk),
    .reset    (reset),
    .inst_reg (inst_reg),
    .b        (b),
    .w        (w),
    .counter  (counter),
    .inst     (inst),
    .d        (d),
    .ans      (ans)
  );

  // Narrow counter instance so wrap-around can also be seen by free-running.
  pic_exec_slice #(.PC_W(4), .DATA_W(8)) dut_small (
    .clk      (clk),
    .reset    (reset),
    .inst_reg (inst_reg),
    .b        (b),
    .w        (w),
    .counter  (s_counter),
    .inst     (s_inst),
    .d        (s_d),
    .ans      (s_ans)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    inst_reg = 8'h1D; w = 8'd25; b = 8'd10;
    reset = 1'b1;
    #0.5;
    n_checks++;
    if (ans !== 9'h000) begin
      n_fail++; $display("FAIL reset_ans: got %h expected %h", ans, 9'h000);
    end
    #0.5;
    reset = 1'b0;
    n_checks++;
    if (counter !== 17'd0) begin
      n_fail++; $display("FAIL reset_counter: got %h expected %h", counter, 17'd0);
    end
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (counter !== 17'd20) begin
      n_fail++; $display("FAIL run20_counter: got %0d expected %0d", counter, 20);
    end
    n_checks++;
    if (s_counter !== 4'd4) begin
      n_fail++; $display("FAIL small_wrap_counter: got %0d expected %0d", s_counter, 4);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.u_pc.count_q = 17'h1FFFF;
    #1;
    release dut.u_pc.count_q;
    #1;
    n_checks++;
    if (counter !== 17'h1FFFF) begin
      n_fail++; $display("FAIL wrap_preload: got %h expected %h", counter, 17'h1FFFF);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (counter !== 17'h00000) begin
      n_fail++; $display("FAIL wrap_counter: got %h expected %h", counter, 17'h00000);
    end
  endtask

  task automatic test_add();
    w = 8'd25; b = 8'd10; inst_reg = 8'h1D;
    #1;
    n_checks++;
    if (inst !== 4'b0000 || d !== 1'b0 || ans !== 9'd35) begin
      n_fail++; $display("FAIL add_w: got inst=%b d=%b ans=%h expected inst=0000 d=0 ans=%h", inst, d, ans, 9'd35);
    end
    inst_reg = 8'h1F;
    #1;
    n_checks++;
    if (inst !== 4'b0000 || d !== 1'b1 || ans !== 9'd35) begin
      n_fail++; $display("FAIL add_f: got inst=%b d=%b ans=%h expected inst=0000 d=1 ans=%h", inst, d, ans, 9'd35);
    end
  endtask

  task automatic test_swap_sub();
    inst_reg = 8'h39; b = 8'h3A;
    #1;
    n_checks++;
    if (inst !== 4'b1010 || ans !== 9'h0A3) begin
      n_fail++; $display("FAIL swap: got inst=%b ans=%h expected inst=1010 ans=0a3", inst, ans);
    end
    inst_reg = 8'h09; w = 8'd25; b = 8'd10;
    #1;
    n_checks++;
    if (inst !== 4'b0100 || ans !== 9'h1F1) begin
      n_fail++; $display("FAIL sub_borrow: got inst=%b ans=%h expected inst=0100 ans=1f1", inst, ans);
    end
  endtask

  task automatic test_clr();
    w = 8'h77; b = 8'h99; inst_reg = 8'h05;
    #1;
    n_checks++;
    if (inst !== 4'b0101 || d !== 1'b0 || ans !== 9'h000) begin
      n_fail++; $display("FAIL clrw: got inst=%b d=%b ans=%h expected inst=0101 d=0 ans=000", inst, d, ans);
    end
    inst_reg = 8'h07;
    #1;
    n_checks++;
    if (inst !== 4'b0101 || d !== 1'b1 || ans !== 9'h000) begin
      n_fail++; $display("FAIL clrf: got inst=%b d=%b ans=%h expected inst=0101 d=1 ans=000", inst, d, ans);
    end
  endtask

  task automatic test_inc_dec();
    w = 8'h00; b = 8'hFF; inst_reg = 8'h29;
    #1;
    n_checks++;
    if (inst !== 4'b1000 || ans !== 9'h100) begin
      n_fail++; $display("FAIL inc_wrap: got inst=%b ans=%h expected inst=1000 ans=100", inst, ans);
    end
    b = 8'h00; inst_reg = 8'h0D;
    #1;
    n_checks++;
    if (inst !== 4'b1001 || ans !== 9'h1FF) begin
      n_fail++; $display("FAIL dec_wrap: got inst=%b ans=%h expected inst=1001 ans=1ff", inst, ans);
    end
  endtask

  typedef struct {
    logic [7:0] ir;
    logic [7:0] wv;
    logic [7:0] bv;
    logic [3:0] op;
    logic       dv;
    logic [8:0] res;
  } vec_t;

  task automatic test_other_ops();
    vec_t tbl [0:11];
    tbl[0]  = '{8'h15, 8'hC5, 8'h5C, 4'b0001, 1'b0, 9'h044}; // AND
    tbl[1]  = '{8'h11, 8'hC5, 8'h5C, 4'b0010, 1'b0, 9'h0DD}; // IOR
    tbl[2]  = '{8'h1B, 8'hC5, 8'h5C, 4'b0011, 1'b1, 9'h099}; // XOR to f
    tbl[3]  = '{8'h21, 8'hC5, 8'h5C, 4'b0110, 1'b0, 9'h05C}; // MOV
    tbl[4]  = '{8'h25, 8'hC5, 8'h5C, 4'b0111, 1'b0, 9'h0A3}; // COM
    tbl[5]  = '{8'h35, 8'hC5, 8'h5C, 4'b1011, 1'b0, 9'h0B8}; // RL, msb 0
    tbl[6]  = '{8'h35, 8'h00, 8'h81, 4'b1011, 1'b0, 9'h103}; // RL, msb 1
    tbl[7]  = '{8'h31, 8'hC5, 8'h5C, 4'b1100, 1'b0, 9'h02E}; // RR, lsb 0
    tbl[8]  = '{8'h31, 8'h00, 8'h81, 4'b1100, 1'b0, 9'h1C0}; // RR, lsb 1
    tbl[9]  = '{8'h02, 8'hC5, 8'h5C, 4'b1101, 1'b1, 9'h0C5}; // MOVW
    tbl[10] = '{8'h1D, 8'hC5, 8'h5C, 4'b0000, 1'b0, 9'h121}; // ADD carry
    tbl[11] = '{8'h09, 8'h10, 8'h30, 4'b0100, 1'b0, 9'h020}; // SUB no borrow
    for (int i = 0; i < 12; i++) begin
      inst_reg = tbl[i].ir; w = tbl[i].wv; b = tbl[i].bv;
      #1;
      n_checks++;
      if (inst !== tbl[i].op || d !== tbl[i].dv || ans !== tbl[i].res) begin
        n_fail++;
        $display("FAIL op_vec%0d: got inst=%b d=%b ans=%h expected inst=%b d=%b ans=%h",
                 i, inst, d, ans, tbl[i].op, tbl[i].dv, tbl[i].res);
      end
    end
  endtask

  task automatic test_nop_reset_override();
    w = 8'h12; b = 8'h34; inst_reg = 8'h01;
    #1;
    n_checks++;
    if (inst !== 4'b1111 || ans !== 9'h000) begin
      n_fail++; $display("FAIL nop: got inst=%b ans=%h expected inst=1111 ans=000", inst, ans);
    end
    inst_reg = 8'hFC;
    #1;
    n_checks++;
    if (inst !== 4'b1111 || ans !== 9'h000) begin
      n_fail++; $display("FAIL undef_op: got inst=%b ans=%h expected inst=1111 ans=000", inst, ans);
    end
    @(negedge clk);
    w = 8'd25; b = 8'd10; inst_reg = 8'h1D;
    reset = 1'b1;
    #1;
    n_checks++;
    if (ans !== 9'h000 || counter !== 17'd0 || inst !== 4'b0000) begin
      n_fail++; $display("FAIL reset_async: got ans=%h counter=%h inst=%b expected ans=000 counter=0 inst=0000", ans, counter, inst);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (ans !== 9'h000 || counter !== 17'd0) begin
      n_fail++; $display("FAIL reset_held: got ans=%h counter=%h expected ans=000 counter=0", ans, counter);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (ans !== 9'd35 || counter !== 17'd0) begin
      n_fail++; $display("FAIL reset_release: got ans=%h counter=%h expected ans=%h counter=0", ans, counter, 9'd35);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (counter !== 17'd1) begin
      n_fail++; $display("FAIL count_after_reset: got %0d expected 1", counter);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    inst_reg = 8'h00;
    w        = 8'h00;
    b        = 8'h00;
    test_reset();
    test_wrap();
    test_add();
    test_swap_sub();
    test_clr();
    test_inc_dec();
    test_other_ops();
    test_nop_reset_override();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
